// File: rtl/bp_cfg_stream_loader.sv
// bp_cfg_stream_loader
//   Holds a table of config records and, on request, streams the selected record
//   as (field index, data) beats broadcast to channels_p tiles, with up to two
//   field overrides applied. Each channel handshakes independently; a beat
//   advances only once every channel has taken it.
// Ports
//   clk_i, reset_n_i      clock, async active-low reset
//   start_i, cfg_id_i     load request (sampled in IDLE only) and record id
//   ovr_v_i/field_i/data_i two override slots (slot 1 wins on same field)
//   v_o, ready_i          per-channel valid / ready
//   field_o, data_o       current beat
//   busy_o, done_o, err_o status; done_o/err_o are one-cycle pulses
//   csum_o                modular sum of streamed data, valid while done_o

// Per-channel handshake tracker: remembers that this channel already took the
// current beat so it is never offered the same beat twice.
module bp_cfg_stream_lane (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic send_i,
  input  logic ready_i,
  input  logic beat_done_i,
  output logic v_o,
  output logic have_o
);
  logic acked_q;
  logic take;

  assign v_o    = send_i & ~acked_q;
  assign take   = v_o & ready_i;
  assign have_o = acked_q | take;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                  acked_q <= 1'b0;
    else if (!send_i || beat_done_i) acked_q <= 1'b0;
    else if (take)                   acked_q <= 1'b1;
  end
endmodule

module bp_cfg_stream_loader #(
  parameter int num_cfgs_p    = 16,
  parameter int num_fields_p  = 48,
  parameter int field_width_p = 16,
  parameter int channels_p    = 4,
  parameter logic [num_cfgs_p*num_fields_p*field_width_p-1:0] cfg_table_p = '0,
  localparam int lg_cfgs_lp   = (num_cfgs_p   > 1) ? $clog2(num_cfgs_p)   : 1,
  localparam int lg_fields_lp = (num_fields_p > 1) ? $clog2(num_fields_p) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      start_i,
  input  logic [lg_cfgs_lp-1:0]     cfg_id_i,
  input  logic [1:0]                ovr_v_i,
  input  logic [2*lg_fields_lp-1:0] ovr_field_i,
  input  logic [2*field_width_p-1:0] ovr_data_i,
  output logic [channels_p-1:0]     v_o,
  input  logic [channels_p-1:0]     ready_i,
  output logic [lg_fields_lp-1:0]   field_o,
  output logic [field_width_p-1:0]  data_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [field_width_p-1:0]  csum_o
);

  typedef enum logic [1:0] {IDLE, SEND, DONE, ERR} state_e;

  typedef struct packed {
    logic [lg_cfgs_lp-1:0]                id;
    logic [1:0]                           ovr_v;
    logic [1:0][lg_fields_lp-1:0]         ovr_field;
    logic [1:0][field_width_p-1:0]        ovr_data;
  } req_t;

  state_e                     state_q, state_d;
  req_t                       req_q, req_d;
  logic [lg_fields_lp-1:0]    cnt_q, cnt_d;
  logic [field_width_p-1:0]   csum_q, csum_d;
  logic [field_width_p-1:0]   fdata;
  logic [channels_p-1:0]      have;
  logic                       send, beat_done, last;
  int                         tbl_idx;

  assign send      = (state_q == SEND);
  assign beat_done = send & (&have);
  assign last      = (cnt_q == lg_fields_lp'(num_fields_p - 1));

  for (genvar c = 0; c < channels_p; c++) begin : g_lane
    bp_cfg_stream_lane u_lane (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .send_i      (send),
      .ready_i     (ready_i[c]),
      .beat_done_i (beat_done),
      .v_o         (v_o[c]),
      .have_o      (have[c])
    );
  end

  // Field value: table lookup, then slot 0, then slot 1 so slot 1 wins on a tie.
  // Slots naming a field beyond the record are never applied.
  always_comb begin
    tbl_idx = int'(req_q.id) * num_fields_p + int'(cnt_q);
    fdata   = cfg_table_p[tbl_idx*field_width_p +: field_width_p];
    for (int s = 0; s < 2; s++) begin
      if (req_q.ovr_v[s] && (req_q.ovr_field[s] == cnt_q) &&
          (int'(req_q.ovr_field[s]) < num_fields_p))
        fdata = req_q.ovr_data[s];
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    case (state_q)
      IDLE: if (start_i) begin
        req_d  = '{id: cfg_id_i, ovr_v: ovr_v_i, ovr_field: ovr_field_i, ovr_data: ovr_data_i};
        cnt_d  = '0;
        csum_d = '0;
        state_d = ((cfg_id_i == '0) || (int'(cfg_id_i) >= num_cfgs_p)) ? ERR : SEND;
      end
      SEND: if (beat_done) begin
        csum_d = csum_q + fdata;
        if (last) state_d = DONE;
        else      cnt_d   = cnt_q + lg_fields_lp'(1);
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign err_o   = (state_q == ERR);
  assign csum_o  = done_o ? csum_q : '0;
  assign field_o = send ? cnt_q : '0;
  assign data_o  = send ? fdata : '0;

endmodule

// File: tb/tb_bp_cfg_stream_loader.sv
module tb_bp_cfg_stream_loader;
  localparam int NC = 4, NF = 3, FW = 8, CH = 2;
  localparam int LC = 2, LF = 2;
  // rec0 = 0s, rec1 = {01,02,03}, rec2 = {10,20,F0}, rec3 = {AA,BB,CC} (field 0 listed first)
  localparam logic [NC*NF*FW-1:0] TBL = {8'hCC, 8'hBB, 8'hAA, 8'hF0, 8'h20, 8'h10,
                                         8'h03, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00};

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [LC-1:0] cfg_id = '0;
  logic [1:0] ovr_v = '0;
  logic [2*LF-1:0] ovr_field = '0;
  logic [2*FW-1:0] ovr_data = '0;
  logic [CH-1:0] v, ready = '1;
  logic [LF-1:0] field;
  logic [FW-1:0] data, csum;
  logic busy, done, err;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  bp_cfg_stream_loader #(.num_cfgs_p(NC), .num_fields_p(NF), .field_width_p(FW),
                         .channels_p(CH), .cfg_table_p(TBL)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .cfg_id_i(cfg_id),
    .ovr_v_i(ovr_v), .ovr_field_i(ovr_field), .ovr_data_i(ovr_data),
    .v_o(v), .ready_i(ready), .field_o(field), .data_o(data),
    .busy_o(busy), .done_o(done), .err_o(err), .csum_o(csum));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [LC-1:0] id;
    logic [1:0]    ov;
    logic [LF-1:0] f0, f1;
    logic [FW-1:0] d0, d1;
    logic          exp_err;
    logic [FW-1:0] exp_data [NF];
    logic [FW-1:0] exp_csum;
  } vec_t;

  vec_t vecs [7];

  task automatic load(input logic [LC-1:0] id, input logic [1:0] ov,
                      input logic [LF-1:0] f0, input logic [FW-1:0] d0,
                      input logic [LF-1:0] f1, input logic [FW-1:0] d1);
    start = 1'b1; cfg_id = id; ovr_v = ov;
    ovr_field = {f1, f0}; ovr_data = {d1, d0};
  endtask

  initial begin
    vecs[0] = '{2'd2, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, '{8'h10, 8'h20, 8'hF0}, 8'h20};
    vecs[1] = '{2'd2, 2'b11, 2'd1, 2'd1, 8'h55, 8'h66, 1'b0, '{8'h10, 8'h66, 8'hF0}, 8'h66};
    vecs[2] = '{2'd2, 2'b11, 2'd3, 2'd1, 8'h77, 8'h66, 1'b0, '{8'h10, 8'h66, 8'hF0}, 8'h66};
    vecs[3] = '{2'd1, 2'b01, 2'd0, 2'd2, 8'h80, 8'h99, 1'b0, '{8'h80, 8'h02, 8'h03}, 8'h85};
    vecs[4] = '{2'd3, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, '{8'hAA, 8'hBB, 8'hCC}, 8'h31};
    vecs[5] = '{2'd0, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, '{8'h00, 8'h00, 8'h00}, 8'h00};
    vecs[6] = '{2'd3, 2'b10, 2'd0, 2'd2, 8'h00, 8'h04, 1'b0, '{8'hAA, 8'hBB, 8'h04}, 8'h69};

    // reset state
    #12;
    chk("rst v_o", v, 0); chk("rst busy", busy, 0); chk("rst done", done, 0);
    chk("rst err", err, 0); chk("rst field", field, 0); chk("rst data", data, 0);
    chk("rst csum", csum, 0);
    rst_n = 1'b1;
    step();

    // table-driven loads, all channels ready
    for (int i = 0; i < 7; i++) begin
      ready = '1;
      load(vecs[i].id, vecs[i].ov, vecs[i].f0, vecs[i].d0, vecs[i].f1, vecs[i].d1);
      step();
      start = 1'b0;
      if (vecs[i].exp_err) begin
        @(negedge clk);
        chk($sformatf("v%0d err", i), err, 1); chk($sformatf("v%0d err v_o", i), v, 0);
        chk($sformatf("v%0d err busy", i), busy, 1);
        step(); @(negedge clk);
        chk($sformatf("v%0d err end", i), err, 0); chk($sformatf("v%0d busy end", i), busy, 0);
        chk($sformatf("v%0d err v_o end", i), v, 0);
      end else begin
        for (int f = 0; f < NF; f++) begin
          @(negedge clk);
          chk($sformatf("v%0d f%0d v_o", i, f), v, 2'b11);
          chk($sformatf("v%0d f%0d field", i, f), field, f);
          chk($sformatf("v%0d f%0d data", i, f), data, vecs[i].exp_data[f]);
          chk($sformatf("v%0d f%0d done", i, f), done, 0);
          step();
        end
        @(negedge clk);
        chk($sformatf("v%0d done", i), done, 1);
        chk($sformatf("v%0d csum", i), csum, vecs[i].exp_csum);
        chk($sformatf("v%0d done v_o", i), v, 0);
        step(); @(negedge clk);
        chk($sformatf("v%0d idle done", i), done, 0);
        chk($sformatf("v%0d idle busy", i), busy, 0);
        chk($sformatf("v%0d idle csum", i), csum, 0);
      end
    end

    // backpressure: ch1 not ready for 3 cycles on f0
    ready = 2'b01;
    load(2'd2, 2'b00, 2'd0, 8'h00, 2'd0, 8'h00);
    step(); start = 1'b0;
    @(negedge clk); chk("bp c1 v_o", v, 2'b11); chk("bp c1 field", field, 0);
    step(); @(negedge clk); chk("bp c2 v_o", v, 2'b10); chk("bp c2 field", field, 0);
    step(); @(negedge clk); chk("bp c3 v_o", v, 2'b10);
    step(); ready = 2'b11;
    @(negedge clk); chk("bp c4 v_o", v, 2'b10); chk("bp c4 field", field, 0);
    chk("bp c4 data", data, 8'h10);
    step(); @(negedge clk); chk("bp f1 v_o", v, 2'b11); chk("bp f1 field", field, 1);
    step(); @(negedge clk); chk("bp f2 field", field, 2);
    step(); @(negedge clk); chk("bp done", done, 1); chk("bp csum", csum, 8'h20);
    step();

    // start held high through a stream; id change mid-stream ignored
    load(2'd2, 2'b00, 2'd0, 8'h00, 2'd0, 8'h00);
    step(); cfg_id = 2'd1;
    for (int f = 0; f < NF; f++) begin
      @(negedge clk);
      chk($sformatf("hold f%0d data", f), data, (f == 0) ? 8'h10 : (f == 1) ? 8'h20 : 8'hF0);
      step();
    end
    @(negedge clk); chk("hold done", done, 1); chk("hold csum", csum, 8'h20);
    step(); @(negedge clk); chk("hold idle busy", busy, 0);
    step(); start = 1'b0;
    @(negedge clk); chk("hold reload v_o", v, 2'b11); chk("hold reload data", data, 8'h01);
    step(); step(); step();
    @(negedge clk); chk("hold reload done", done, 1); chk("hold reload csum", csum, 8'h06);
    step();

    // async reset mid-f1
    load(2'd2, 2'b00, 2'd0, 8'h00, 2'd0, 8'h00);
    step(); start = 1'b0;
    step();
    @(negedge clk); chk("rst mid field", field, 1);
    #1 rst_n = 1'b0;
    #1; chk("rst mid v_o", v, 0); chk("rst mid busy", busy, 0);
    step(); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post rst done %0d", k), done, 0);
      chk($sformatf("post rst err %0d", k), err, 0);
      chk($sformatf("post rst busy %0d", k), busy, 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
